spi_mosi_rx: RTL and testbench

- SPI slave-side receiver for the single-wire MOSI link driven by the team's SPI master transmitter.
- Samples the master's sclk/sda pins in the local clk domain and assembles bytes MSB first on sclk rising edges (sclk idles low; master changes sda on falling edges).
- Presents each byte on a one-entry valid/ready output register.
- Flags overrun and broken frames.

---
 rtl/spi_mosi_rx.sv | 175 +++++++++++++++++
 tb/tb_spi_mosi_rx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mosi_rx.sv
// SPI slave MOSI receiver: synchronizes sclk/sda, shifts bytes in MSB first on sclk rises
// and holds each byte in a one-entry valid/ready register. Optional chip select: SPI_RX_CS_EN.
module spi_mosi_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  sda,
  input  logic                  cs,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  overrun,
  input  logic                  ovr_clr,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q,  sda_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic [DATA_WIDTH-2:0]  shift_q,     shift_d;
  logic [CNT_W-1:0]       cnt_q,       cnt_d;
  logic [TMO_W-1:0]       tmo_q,       tmo_d;
  logic [DATA_WIDTH-1:0]  data_q,      data_d;
  logic                   valid_q,     valid_d;
  logic                   ovr_q,       ovr_d;
  logic                   ferr_q,      ferr_d;

  logic                   sclk_s, sda_s, rise, complete, ovr_set;
  logic [DATA_WIDTH-1:0]  new_byte;
  logic                   cs_block, cs_abort, cs_restart;

  assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign new_byte = {shift_q, sda_s};
  assign rise     = sclk_s & ~sclk_prev_q & ~cs_block;

`ifdef SPI_RX_CS_EN
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic                   cs_prev_q;
  logic                   cs_s;

  assign cs_s       = cs_sync_q[SYNC_STAGES-1];
  assign cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], cs};
  assign cs_block   = cs_s;
  // Deselect mid-frame is a broken frame; a fresh select always restarts framing.
  assign cs_abort   = cs_s & ~cs_prev_q & (cnt_q != '0);
  assign cs_restart = ~cs_s & cs_prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync_q <= '1;
      cs_prev_q <= 1'b1;
    end else begin
      cs_sync_q <= cs_sync_d;
      cs_prev_q <= cs_s;
    end
  end
`else
  logic unused_cs;

  assign unused_cs  = cs;
  assign cs_block   = 1'b0;
  assign cs_abort   = 1'b0;
  assign cs_restart = 1'b0;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    sda_sync_d  = {sda_sync_q[SYNC_STAGES-2:0], sda};
    sclk_prev_d = sclk_s;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    ferr_d      = 1'b0;
    complete    = 1'b0;

    if (rise) begin
      shift_d = new_byte[DATA_WIDTH-2:0];
      tmo_d   = '0;
      if (cnt_q == CNT_LAST) begin
        cnt_d    = '0;
        complete = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (cnt_q != '0) begin
      // A rise always beats expiry, so the timeout is only evaluated here.
      if (tmo_q == TMO_LAST) begin
        cnt_d   = '0;
        shift_d = '0;
        tmo_d   = '0;
        ferr_d  = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    if (cs_abort) begin
      cnt_d   = '0;
      shift_d = '0;
      tmo_d   = '0;
      ferr_d  = 1'b1;
    end
    if (cs_restart) begin
      cnt_d = '0;
      tmo_d = '0;
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    ovr_set = 1'b0;

    if (valid_q && rx_ready) valid_d = 1'b0;
    if (complete) begin
      // A byte accepted in the completion cycle frees the slot for the new one.
      if (!valid_q || rx_ready) begin
        data_d  = new_byte;
        valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end

    if (ovr_clr) ovr_d = 1'b0;
    if (ovr_set) ovr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (reset) begin
      sclk_sync_q <= '0;
      sda_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ovr_q       <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      sda_sync_q  <= sda_sync_d;
      sclk_prev_q <= sclk_prev_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      ovr_q       <= ovr_d;
      ferr_q      <= ferr_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign overrun   = ovr_q;
  assign frame_err = ferr_q;
  assign busy      = (cnt_q != '0);

endmodule

// File: tb/tb_spi_mosi_rx.sv
// Bench for spi_mosi_rx: directed SPI frames, expected bytes queued on send and
// compared by a handshake monitor; timing and flag checks done inline.
module tb_spi_mosi_rx;

  localparam int SYNC    = 2;
  localparam int DW      = 8;
  localparam int TMO     = 1024;
  localparam int HALF    = 64;
  localparam int FE_LAT  = SYNC + 1 + TMO;
  localparam int VLD_LAT = SYNC + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sclk = 1'b0;
  logic          sda = 1'b0;
  logic          cs = 1'b0;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready = 1'b0;
  logic          overrun;
  logic          ovr_clr = 1'b0;
  logic          frame_err;
  logic          busy;

  spi_mosi_rx #(.SYNC_STAGES(SYNC), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .sda(sda), .cs(cs),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .overrun(overrun), .ovr_clr(ovr_clr), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            rise_cyc = 0;
  int            fe_count = 0, fe_cycles = 0, fe_cyc = 0;
  int            vld_rise_cyc = 0, vld_run = 0, vld_last_run = 0;
  logic          prev_fe = 1'b0, prev_vld = 1'b0, prev_hs = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [DW-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Handshake monitor: pops the scoreboard and watches valid/frame_err pulse shapes.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid && prev_vld && !prev_hs) check("rx_data_stable", rx_data, prev_data);
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) check("unexpected_byte", rx_data, 32'hFFFF_FFFF);
        else check("rx_data", rx_data, exp_q.pop_front());
      end
      if (rx_valid) begin
        if (!prev_vld) vld_rise_cyc = cyc;
        vld_run++;
      end else if (prev_vld) begin
        vld_last_run = vld_run;
        vld_run = 0;
      end
      if (frame_err) begin
        fe_cycles++;
        if (!prev_fe) begin
          fe_count++;
          fe_cyc = cyc;
        end
      end
    end else begin
      vld_run = 0;
    end
    prev_fe   = frame_err;
    prev_vld  = rx_valid;
    prev_hs   = rx_valid & rx_ready;
    prev_data = rx_data;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_lead(input logic b);
    @(posedge clk);
    #1 sda = b;
    wait_clks(HALF - 1);
  endtask

  task automatic bit_rise();
    @(posedge clk);
    #1 sclk = 1'b1;
    rise_cyc = cyc;
  endtask

  task automatic bit_fall();
    wait_clks(HALF - 1);
    sclk = 1'b0;
  endtask

  // Sends the top n bits of d, MSB first.
  task automatic send_bits(input logic [DW-1:0] d, input int n);
    for (int i = DW - 1; i >= DW - n; i--) begin
      bit_lead(d[i]);
      bit_rise();
      bit_fall();
    end
  endtask

  task automatic pulse_ready();
    @(posedge clk);
    #1 rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
  endtask

  int fe_before;

  initial begin
    wait_clks(4);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_data", rx_data, 0);
    check("reset_overrun", overrun, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_busy", busy, 0);
    reset = 1'b0;
    wait_clks(4);

    // 1: single byte, consumer always ready
    rx_ready = 1'b1;
    fe_before = fe_count;
    exp_q.push_back(8'hA5);
    send_bits(8'hA5, 8);
    wait_clks(10);
    check("t1_valid_width", vld_last_run, 1);
    check("t1_valid_latency", vld_rise_cyc - rise_cyc, VLD_LAT);
    check("t1_overrun", overrun, 0);
    check("t1_no_frame_err", fe_count, fe_before);

    // 2: overrun while the first byte is held
    rx_ready = 1'b0;
    exp_q.push_back(8'h3C);
    send_bits(8'h3C, 8);
    wait_clks(4);
    check("t2_valid_first", rx_valid, 1);
    check("t2_data_first", rx_data, 8'h3C);
    check("t2_no_overrun_yet", overrun, 0);
    send_bits(8'hC3, 8);
    wait_clks(4);
    check("t2_data_kept", rx_data, 8'h3C);
    check("t2_overrun_set", overrun, 1);
    pulse_ready();
    wait_clks(2);
    check("t2_valid_cleared", rx_valid, 0);
    check("t2_overrun_sticky", overrun, 1);
    @(posedge clk);
    #1 ovr_clr = 1'b1;
    @(posedge clk);
    #1 ovr_clr = 1'b0;
    wait_clks(1);
    check("t2_overrun_cleared", overrun, 0);

    // 3: partial frame times out, then a clean frame
    rx_ready = 1'b1;
    fe_before = fe_count;
    send_bits(8'hB8, 5);
    check("t3_busy_partial", busy, 1);
    wait_clks(1100);
    check("t3_one_frame_err", fe_count, fe_before + 1);
    check("t3_frame_err_width", fe_cycles, fe_count);
    check("t3_frame_err_latency", fe_cyc - rise_cyc, FE_LAT);
    check("t3_busy_idle", busy, 0);
    exp_q.push_back(8'h81);
    send_bits(8'h81, 8);
    wait_clks(4);
    check("t3_drained", exp_q.size(), 0);

    // 4: reset mid-frame with a byte held and a partial frame in progress
    rx_ready = 1'b0;
    send_bits(8'h42, 8);
    send_bits(8'hF0, 4);
    check("t4_busy_before", busy, 1);
    check("t4_valid_before", rx_valid, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    wait_clks(1);
    check("t4_rst_rx_valid", rx_valid, 0);
    check("t4_rst_rx_data", rx_data, 0);
    check("t4_rst_overrun", overrun, 0);
    check("t4_rst_frame_err", frame_err, 0);
    check("t4_rst_busy", busy, 0);
    reset = 1'b0;
    wait_clks(4);
    exp_q.push_back(8'hFF);
    send_bits(8'hFF, 8);
    wait_clks(4);
    check("t4_data_ff", rx_data, 8'hFF);
    pulse_ready();
    wait_clks(2);

    // 5: ready raised exactly in the completion cycle of the second frame
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_bits(8'h11, 8);
    send_bits(8'h22, 7);
    bit_lead(1'b0);
    bit_rise();
    repeat (SYNC) @(posedge clk);
    #1 rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    check("t5_valid_held", rx_valid, 1);
    check("t5_data_new", rx_data, 8'h22);
    check("t5_no_overrun", overrun, 0);
    bit_fall();
    pulse_ready();
    wait_clks(2);
    check("t5_drained", exp_q.size(), 0);

`ifdef SPI_RX_CS_EN
    // 6: deselect mid-frame, clocks while deselected, then a clean frame
    rx_ready = 1'b1;
    fe_before = fe_count;
    send_bits(8'hE0, 3);
    @(posedge clk);
    #1 cs = 1'b1;
    wait_clks(10);
    check("t6_cs_frame_err", fe_count, fe_before + 1);
    send_bits(8'hFF, 4);
    wait_clks(4);
    check("t6_busy_deselected", busy, 0);
    cs = 1'b0;
    wait_clks(10);
    exp_q.push_back(8'h5A);
    send_bits(8'h5A, 8);
    wait_clks(4);
    check("t6_single_frame_err", fe_count, fe_before + 1);
    check("t6_drained", exp_q.size(), 0);
`endif

    wait_clks(10);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_frame_err_width", fe_cycles, fe_count);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
